mp_add_seq: RTL and testbench

Multi-precision add/subtract sequencer. It accepts two N*WORDS-bit operands and produces the full-width result by time-multiplexing a single N-bit carry-in/carry-out adder, one word per cycle, LSW first. The carry is registered between words. It sits between a requesting datapath stage (start handshake) and a consuming stage (result handshake), trading latency for area on wide arithmetic.

---
 rtl/mp_add_pkg.sv | 15 +
 rtl/mp_add_seq_add_n.sv | 19 +
 rtl/mp_add_seq.sv | 91 +++++++++
 tb/tb_mp_add_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// rtl/mp_add_pkg.sv - shared state encoding and sizing helper for mp_add_seq
package mp_add_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Word index width; a single-word operand still needs a 1-bit index.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mp_add_seq_add_n.sv
// rtl/mp_add_seq_add_n.sv - combinational N-bit adder with carry in/out
module add_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] total;

    // One extra bit captures the carry out of the word.
    assign total = {1'b0, x} + {1'b0, y} + (N+1)'(ci);
    assign s     = total[N-1:0];
    assign co    = total[N];

endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - word-serial multi-precision add/subtract sequencer
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               busy
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [N-1:0]    add_s;
    logic            add_co;

    // Operands are shift registers, so the adder always sees the low word.
    add_n #(.N(N)) u_add (
        .x  (a_reg[N-1:0]),
        .y  (b_reg[N-1:0]),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    // Sequencer: capture operands, ripple one word per cycle, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_reg <= a;
                        // Subtraction becomes a + ~b + ~cin.
                        b_reg <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[int'(idx)*N +: N] <= add_s;
                    carry <= add_co;
                    a_reg <= a_reg >> N;
                    b_reg <= b_reg >> N;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        cout  <= add_co;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready = (state == ST_IDLE);
    assign res_valid   = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - self-checking bench for mp_add_seq (8x4 and 32x1)
module tb_mp_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sv    [2];
    logic        sr    [2];
    logic [31:0] a_i   [2];
    logic [31:0] b_i   [2];
    logic        cin_i [2];
    logic        sub_i [2];
    logic        rv    [2];
    logic        rr    [2];
    logic [31:0] sum_o [2];
    logic        cout_o[2];
    logic        busy_o[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mp_add_seq #(.N(8), .WORDS(4)) dut4 (
        .clk(clk), .rst(rst),
        .start_valid(sv[0]), .start_ready(sr[0]),
        .a(a_i[0]), .b(b_i[0]), .cin(cin_i[0]), .sub(sub_i[0]),
        .res_valid(rv[0]), .res_ready(rr[0]),
        .sum(sum_o[0]), .cout(cout_o[0]), .busy(busy_o[0])
    );

    mp_add_seq #(.N(32), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .start_valid(sv[1]), .start_ready(sr[1]),
        .a(a_i[1]), .b(b_i[1]), .cin(cin_i[1]), .sub(sub_i[1]),
        .res_valid(rv[1]), .res_ready(rr[1]),
        .sum(sum_o[1]), .cout(cout_o[1]), .busy(busy_o[1])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation on DUT d; returns the captured result and the
    // number of edges from the start handshake to the first res_valid.
    task automatic run_op(input int d, input logic [31:0] aa, input logic [31:0] bb,
                          input logic ci, input logic su, input int stall,
                          input bit pre_rdy, output logic [31:0] s,
                          output logic co, output int lat);
        int t;
        t = 0;
        while (!sr[d] && t < 50) begin
            tick();
            t++;
        end
        chk("start_ready_wait", 64'(sr[d]), 64'd1);
        a_i[d] = aa; b_i[d] = bb; cin_i[d] = ci; sub_i[d] = su;
        sv[d] = 1'b1;
        rr[d] = pre_rdy;
        tick();
        sv[d] = 1'b0;
        a_i[d] = $urandom; b_i[d] = $urandom; cin_i[d] = ~ci; sub_i[d] = ~su;
        lat = 0;
        while (!rv[d] && lat < 50) begin
            tick();
            lat++;
        end
        chk("res_valid_wait", 64'(rv[d]), 64'd1);
        s  = sum_o[d];
        co = cout_o[d];
        if (!pre_rdy) begin
            repeat (stall) tick();
            if (stall > 0) begin
                chk("stall_sum", 64'(sum_o[d]), 64'(s));
                chk("stall_rv", 64'(rv[d]), 64'd1);
            end
            rr[d] = 1'b1;
        end
        tick();
        rr[d] = 1'b0;
        chk("rv_after_hs", 64'(rv[d]), 64'd0);
        chk("ready_after_hs", 64'(sr[d]), 64'd1);
    endtask

    initial begin
        logic [31:0] s, hs, ra, rb;
        logic        co, hc, rc, rs;
        logic [32:0] full;
        int          lat;

        for (int d = 0; d < 2; d++) begin
            sv[d] = 0; rr[d] = 0; a_i[d] = 0; b_i[d] = 0; cin_i[d] = 0; sub_i[d] = 0;
        end

        tv[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0};
        tv[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1};
        tv[2] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1};
        tv[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0};
        tv[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1};
        tv[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0};
        tv[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1};
        tv[7] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_start_ready", 64'(sr[d]), 64'd1);
            chk("rst_res_valid", 64'(rv[d]), 64'd0);
            chk("rst_busy", 64'(busy_o[d]), 64'd0);
            chk("rst_sum", 64'(sum_o[d]), 64'd0);
            chk("rst_cout", 64'(cout_o[d]), 64'd0);
        end

        // Directed table on both configurations
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                run_op(d, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, 2, (i % 2) == 0, s, co, lat);
                chk($sformatf("vec%0d_d%0d_sum", i, d), 64'(s), 64'(tv[i].s));
                chk($sformatf("vec%0d_d%0d_cout", i, d), 64'(co), 64'(tv[i].co));
                chk($sformatf("vec%0d_d%0d_lat", i, d), 64'(lat), (d == 0) ? 64'd4 : 64'd1);
            end
        end

        // Hold DONE with res_ready low while start_valid pulses
        a_i[0] = 32'h00000007; b_i[0] = 32'h00000005; cin_i[0] = 0; sub_i[0] = 1;
        sv[0] = 1'b1;
        tick();
        sv[0] = 1'b0;
        lat = 0;
        while (!rv[0] && lat < 50) begin
            tick();
            lat++;
        end
        chk("hold_enter", 64'(rv[0]), 64'd1);
        hs = sum_o[0];
        hc = cout_o[0];
        chk("hold_sum_val", 64'(hs), 64'h2);
        for (int i = 0; i < 10; i++) begin
            sv[0] = i[0];
            a_i[0] = $urandom; b_i[0] = $urandom;
            tick();
            chk("hold_rv", 64'(rv[0]), 64'd1);
            chk("hold_sum", 64'(sum_o[0]), 64'(hs));
            chk("hold_cout", 64'(cout_o[0]), 64'(hc));
            chk("hold_start_ready", 64'(sr[0]), 64'd0);
            chk("hold_busy", 64'(busy_o[0]), 64'd1);
        end
        sv[0] = 1'b0;
        rr[0] = 1'b1;
        tick();
        rr[0] = 1'b0;
        chk("hold_release_ready", 64'(sr[0]), 64'd1);
        chk("hold_release_busy", 64'(busy_o[0]), 64'd0);
        run_op(0, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 0, 1'b0, s, co, lat);
        chk("hold_next_sum", 64'(s), 64'h3);

        // Reset during the second RUN cycle
        a_i[0] = 32'h000000FF; b_i[0] = 32'h00000022; cin_i[0] = 0; sub_i[0] = 0;
        sv[0] = 1'b1;
        tick();
        sv[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_start_ready", 64'(sr[0]), 64'd1);
        chk("midrst_res_valid", 64'(rv[0]), 64'd0);
        chk("midrst_busy", 64'(busy_o[0]), 64'd0);
        chk("midrst_sum", 64'(sum_o[0]), 64'd0);
        run_op(0, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1, 1'b0, s, co, lat);
        chk("midrst_next_sum", 64'(s), 64'h23456789);
        chk("midrst_next_cout", 64'(co), 64'd0);

        // Random operations against a subtract/add reference model
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom; rb = $urandom;
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                if (rs) begin
                    full = {1'b0, ra} - {1'b0, rb} - 33'(rc);
                    full[32] = ~full[32];
                end else begin
                    full = {1'b0, ra} + {1'b0, rb} + 33'(rc);
                end
                run_op(d, ra, rb, rc, rs, $urandom_range(0, 3), $urandom_range(0, 1) == 1, s, co, lat);
                chk($sformatf("rnd_d%0d_%0d_sum", d, i), 64'(s), 64'(full[31:0]));
                chk($sformatf("rnd_d%0d_%0d_cout", d, i), 64'(co), 64'(full[32]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
